// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: data width, frame lengths and FSM state encoding.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty decode from the registered count.
module sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed from a byte FIFO; define UART_TX_PARITY_EN
// to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_busy,
  output logic              o_ovf,
  output logic              o_tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  uart_state_t       r_state;
  uart_state_t       w_next;
  logic [CNT_W-1:0]  r_baud;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_ovf;
  logic              w_pop;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;

  sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_we),
    .i_pop   (w_pop),
    .i_data  (i_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bit_end = (r_baud == CNT_LAST);
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_busy    = (r_state != ST_IDLE) || !w_empty;
  assign o_ovf     = r_ovf;
  assign o_tx      = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_START;
        end
      end
      ST_START: if (w_bit_end) w_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && (r_idx == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
`endif
      ST_STOP: if (w_bit_end) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_bit_end) r_baud <= '0;
      else                                 r_baud <= r_baud + CNT_ONE;
      if (r_state == ST_START)                 r_idx <= '0;
      else if (r_state == ST_DATA && w_bit_end) r_idx <= r_idx + IDX_ONE;
      if (i_we && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop)                               r_shift <= w_head;
    else if (r_state == ST_DATA && w_bit_end) r_shift <= r_shift >> 1;
  end

`ifdef UART_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (w_pop) r_par <= ^w_head;
  end
`endif

  // Line register follows the current state, so o_tx lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 1'b1;
    end else begin
      unique case (r_state)
        ST_START:  r_tx <= 1'b0;
        ST_DATA:   r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: r_tx <= r_par;
`endif
        default:   r_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random writes compared per cycle with a queue/timeline model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, busy, ovf, tx;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  logic       m_line[$];
  int         m_txleft = 0;
  logic       m_ovf = 1'b0;
  logic       exp_tx = 1'b1;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (we),
    .i_data  (din),
    .o_full  (full),
    .o_empty (empty),
    .o_busy  (busy),
    .o_ovf   (ovf),
    .o_tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_q.delete();
    m_line.delete();
    m_txleft = 0;
    m_ovf    = 1'b0;
    exp_tx   = 1'b1;
  endtask

  // Expected line levels for one frame: start, 8 data bits LSB first, [parity], stop.
  task automatic append_frame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < CPB; c++) m_line.push_back(bits[k]);
  endtask

  task automatic step(input logic w, input logic [7:0] d);
    logic ok;
    logic [7:0] b;
    we  = w;
    din = d;
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      exp_tx = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
      ok = w && (m_q.size() < DEPTH);
      if (w && !ok) m_ovf = 1'b1;
      if (m_txleft == 0 && m_q.size() > 0) begin
        b = m_q.pop_front();
        append_frame(b);
        m_txleft = FRAME_BITS * CPB;
      end else if (m_txleft > 0) begin
        m_txleft--;
      end
      if (ok) m_q.push_back(d);
    end
    @(negedge clk);
    we = 1'b0;
    chk("tx",    {7'd0, tx},    {7'd0, exp_tx});
    chk("full",  {7'd0, full},  {7'd0, logic'(m_q.size() == DEPTH)});
    chk("empty", {7'd0, empty}, {7'd0, logic'(m_q.size() == 0)});
    chk("busy",  {7'd0, busy},  {7'd0, logic'(m_txleft > 0 || m_q.size() > 0)});
    chk("ovf",   {7'd0, ovf},   {7'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    reset_pulse();
    idle(50);

    // Single byte: line must read start, 1,0,1,0,0,1,0,1, stop.
    step(1'b1, 8'hA5);
    chk("a5_pre_fall", {7'd0, tx}, 8'h01);
    step(1'b0, 8'h00);
    chk("a5_hold", {7'd0, tx}, 8'h01);
    step(1'b0, 8'h00);
    chk("a5_start", {7'd0, tx}, 8'h00);
    idle(45);

    // Burst of 16 consecutive writes.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
    idle(800);

    // Overflow: transmitter busy, then 17 writes; the 17th is dropped.
    step(1'b1, 8'($urandom));
    idle(2);
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom));
    chk("ovf_set", {7'd0, ovf}, 8'h01);
    idle(800);
    chk("ovf_sticky", {7'd0, ovf}, 8'h01);
    reset_pulse();
    chk("ovf_clr", {7'd0, ovf}, 8'h00);

    // Random writes of random bytes.
    for (int i = 0; i < 300; i++) step(($urandom_range(0, 3) == 0), 8'($urandom));
    idle(800);

    // Parity-relevant bytes (8E1 parity 1 then 0 when enabled).
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    idle(120);

    // Asynchronous reset during data bit 3 of 8'hFF.
    step(1'b1, 8'hFF);
    idle(18);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",    {7'd0, tx},    8'h01);
    chk("mid_rst_empty", {7'd0, empty}, 8'h01);
    chk("mid_rst_busy",  {7'd0, busy},  8'h00);
    mreset();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
